pulse_stretcher: RTL

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher_pkg.sv | 18 +
 rtl/pulse_stretcher_if.sv | 28 ++
 rtl/pulse_stretcher_tick_prescaler.sv | 36 +++
 rtl/pulse_stretcher.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher.
// Holds the FSM state enum, the pending-count width and a counter-width helper.
package pulse_stretcher_pkg;

    localparam int unsigned PendW = 3;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StGap
    } state_e;

    // $clog2 collapses to 0 for a terminal count of 1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / stretched-level-out signal bundle of the pulse stretcher.
// The slave modport is the stretcher itself; master is whoever feeds it events.
interface pulse_stretcher_if;
    import pulse_stretcher_pkg::*;

    logic             pulse_in;
    logic             stretched_out;
    logic             busy;
    logic [PendW-1:0] pending;
    logic             overflow;

    modport master (
        output pulse_in,
        input  stretched_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output stretched_out,
        output busy,
        output pending,
        output overflow
    );

endinterface

// File: rtl/pulse_stretcher_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 prescaler producing a one-cycle tick at the terminal count.
// clear restarts the count so a new FSM window always begins on a tick boundary.
module tick_prescaler
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CntW    = cnt_width(TICK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q, count_d;

    assign tick = (count_q == CntLast);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-width HOLD windows separated by GAP windows,
// queueing up to PEND_MAX extra events. Define PULSE_STRETCHER_RETRIGGER_EN to make an
// event during HOLD restart the hold timer instead of queueing.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 250000,
    parameter int unsigned HOLD_TICKS = 40,
    parameter int unsigned GAP_TICKS  = 8,
    parameter int unsigned PEND_MAX   = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    pulse_stretcher_if.slave   bus
);

    localparam int unsigned      TickMax  = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int unsigned      TickW    = cnt_width(TickMax);
    localparam logic [TickW-1:0] HoldLast = TickW'(HOLD_TICKS - 1);
    localparam logic [TickW-1:0] GapLast  = TickW'(GAP_TICKS - 1);
    localparam logic [PendW-1:0] PendMax  = PendW'(PEND_MAX);

    state_e           state_q, state_d;
    logic [TickW-1:0] ticks_q, ticks_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic             stretched_q;
    logic             tick;
    logic             clear;
    logic             retrig;
    logic             hold_end;
    logic             gap_end;
    logic             overflow;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .tick    (tick)
    );

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    assign retrig = (state_q == StHold) && bus.pulse_in;
`else
    assign retrig = 1'b0;
`endif

    assign hold_end = (state_q == StHold) && tick && (ticks_q == HoldLast) && !retrig;
    assign gap_end  = (state_q == StGap) && tick && (ticks_q == GapLast);

    // Next state, queue and overflow.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        overflow = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.pulse_in) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (hold_end) begin
                    state_d = StGap;
                end
                if (bus.pulse_in && !retrig) begin
                    if (pend_q == PendMax) begin
                        overflow = 1'b1;
                    end else begin
                        pend_d = pend_q + 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_end) begin
                    // An event arriving right at the gap end is consumed directly, so it
                    // cancels the decrement and is never lost into an IDLE transition.
                    if (bus.pulse_in) begin
                        state_d = StHold;
                    end else if (pend_q != '0) begin
                        state_d = StHold;
                        pend_d  = pend_q - 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bus.pulse_in) begin
                    if (pend_q == PendMax) begin
                        overflow = 1'b1;
                    end else begin
                        pend_d = pend_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Every window starts from a fresh prescaler and tick count.
    assign clear = (state_d != state_q) || retrig;

    always_comb begin
        ticks_d = ticks_q;
        if (clear || (state_q == StIdle)) begin
            ticks_d = '0;
        end else if (tick) begin
            ticks_d = ticks_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ticks_q     <= '0;
            pend_q      <= '0;
            stretched_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ticks_q     <= ticks_d;
            pend_q      <= pend_d;
            stretched_q <= (state_d == StHold);
        end
    end

    assign bus.stretched_out = stretched_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.pending       = pend_q;
    assign bus.overflow      = overflow;

endmodule
